// File: rtl/matrix_op_scheduler.sv
// matrix_op_scheduler
// Time-shares one matrix_sum engine among NUM_REQ clients. A round-robin
// arbiter picks a winner, whose operands are latched. The engine is then
// pulsed through reset and commanded until it reports ready, or until the
// timeout expires. The result goes back to the winner with a done pulse.
// All outputs are registered and follow the FSM state by one cycle, so
// the engine reset pulse overlaps the first WAIT cycle and hides any
// ready flag left over from the previous job.
module matrix_op_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int MATRIX_SIZE_M  = 3,
  parameter int MATRIX_SIZE_N  = 2,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SIZE_BLOCK    = MATRIX_SIZE_M * MATRIX_SIZE_N * DATA_WIDTH
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*SIZE_BLOCK-1:0] i_matrix_a_bus,
  input  logic [NUM_REQ*SIZE_BLOCK-1:0] i_matrix_b_bus,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic [NUM_REQ-1:0]            o_done,
  output logic                          o_error,
  output logic [SIZE_BLOCK-1:0]         o_matrix,
  output logic                          o_eng_rst_n,
  output logic                          o_eng_calc_cmd,
  output logic [SIZE_BLOCK-1:0]         o_eng_matrix_a,
  output logic [SIZE_BLOCK-1:0]         o_eng_matrix_b,
  input  logic [SIZE_BLOCK-1:0]         i_eng_matrix,
  input  logic                          i_eng_ready
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ENG_RST,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       winner_reg, winner_next;
  logic [IDX_W-1:0]       rr_last_reg, rr_last_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   timeout_reg, timeout_next;
  logic [SIZE_BLOCK-1:0]  result_reg, result_next;

  logic [NUM_REQ-1:0]     grant_reg, grant_next;
  logic [NUM_REQ-1:0]     done_reg, done_next;
  logic                   error_reg, error_next;
  logic [SIZE_BLOCK-1:0]  matrix_reg, matrix_next;
  logic                   eng_rst_n_reg, eng_rst_n_next;
  logic                   calc_cmd_reg, calc_cmd_next;
  logic [SIZE_BLOCK-1:0]  eng_a_reg, eng_a_next;
  logic [SIZE_BLOCK-1:0]  eng_b_reg, eng_b_next;

  logic [SIZE_BLOCK-1:0]  slot_a [NUM_REQ];
  logic [SIZE_BLOCK-1:0]  slot_b [NUM_REQ];
  logic [IDX_W-1:0]       cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]     winner_onehot;
  logic [IDX_W-1:0]       pick_idx;

  // Per-slot operand views, winner decode and the round-robin search order
  // (cand_idx[0] is the requester right after the last winner).
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      assign slot_a[gi]        = i_matrix_a_bus[gi*SIZE_BLOCK +: SIZE_BLOCK];
      assign slot_b[gi]        = i_matrix_b_bus[gi*SIZE_BLOCK +: SIZE_BLOCK];
      assign winner_onehot[gi] = (winner_reg == IDX_W'(gi));
      assign cand_idx[gi]      = IDX_W'((int'(rr_last_reg) + gi + 1) % NUM_REQ);
    end
  endgenerate

  // Round-robin pick: scan from lowest to highest priority so the nearest
  // requester after rr_last overrides the others.
  always_comb begin
    pick_idx = rr_last_reg;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[cand_idx[k]]) begin
        pick_idx = cand_idx[k];
      end
    end
  end

  // Next-state and next-output logic for the job sequencer.
  always_comb begin
    state_next     = state_reg;
    winner_next    = winner_reg;
    rr_last_next   = rr_last_reg;
    cnt_next       = cnt_reg;
    timeout_next   = timeout_reg;
    result_next    = result_reg;
    grant_next     = grant_reg;
    done_next      = '0;
    error_next     = error_reg;
    matrix_next    = matrix_reg;
    eng_rst_n_next = 1'b1;
    calc_cmd_next  = 1'b0;
    eng_a_next     = eng_a_reg;
    eng_b_next     = eng_b_reg;

    case (state_reg)
      S_IDLE: begin
        grant_next = '0;
        error_next = 1'b0;
        if (|i_req) begin
          winner_next = pick_idx;
          state_next  = S_LOAD;
        end
      end
      S_LOAD: begin
        grant_next = winner_onehot;
        eng_a_next = slot_a[winner_reg];
        eng_b_next = slot_b[winner_reg];
        state_next = S_ENG_RST;
      end
      S_ENG_RST: begin
        eng_rst_n_next = 1'b0;
        state_next     = S_WAIT;
      end
      S_WAIT: begin
        calc_cmd_next = 1'b1;
        cnt_next      = cnt_reg + CNT_W'(1);
        if (i_eng_ready) begin
          result_next  = i_eng_matrix;
          timeout_next = 1'b0;
          state_next   = S_DONE;
        end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_next = 1'b1;
          state_next   = S_DONE;
        end
      end
      S_DONE: begin
        done_next    = winner_onehot;
        error_next   = timeout_reg;
        if (!timeout_reg) begin
          matrix_next = result_reg;
        end
        cnt_next     = '0;
        rr_last_next = winner_reg;
        state_next   = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset parks the engine in reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= S_IDLE;
      winner_reg    <= '0;
      rr_last_reg   <= IDX_W'(NUM_REQ - 1);
      cnt_reg       <= '0;
      timeout_reg   <= 1'b0;
      result_reg    <= '0;
      grant_reg     <= '0;
      done_reg      <= '0;
      error_reg     <= 1'b0;
      matrix_reg    <= '0;
      eng_rst_n_reg <= 1'b0;
      calc_cmd_reg  <= 1'b0;
      eng_a_reg     <= '0;
      eng_b_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      winner_reg    <= winner_next;
      rr_last_reg   <= rr_last_next;
      cnt_reg       <= cnt_next;
      timeout_reg   <= timeout_next;
      result_reg    <= result_next;
      grant_reg     <= grant_next;
      done_reg      <= done_next;
      error_reg     <= error_next;
      matrix_reg    <= matrix_next;
      eng_rst_n_reg <= eng_rst_n_next;
      calc_cmd_reg  <= calc_cmd_next;
      eng_a_reg     <= eng_a_next;
      eng_b_reg     <= eng_b_next;
    end
  end

  assign o_grant        = grant_reg;
  assign o_done         = done_reg;
  assign o_error        = error_reg;
  assign o_matrix       = matrix_reg;
  assign o_eng_rst_n    = eng_rst_n_reg;
  assign o_eng_calc_cmd = calc_cmd_reg;
  assign o_eng_matrix_a = eng_a_reg;
  assign o_eng_matrix_b = eng_b_reg;

endmodule

// File: tb/tb_matrix_op_scheduler.sv
// Testbench for matrix_op_scheduler: directed scenarios with literal
// expectations, then randomized traffic. A job-timeline model predicts
// every output on every cycle, and a small engine stand-in provides
// i_eng_ready and i_eng_matrix.
module tb_matrix_op_scheduler;
  localparam int NR = 4;
  localparam int MM = 3;
  localparam int MN = 2;
  localparam int DW = 16;
  localparam int TO = 8;
  localparam int NE = MM * MN;
  localparam int SB = NE * DW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [NR*SB-1:0] a_bus = '0;
  logic [NR*SB-1:0] b_bus = '0;
  logic [NR-1:0]    grant, done;
  logic             error;
  logic [SB-1:0]    matrix;
  logic             eng_rst_n, calc_cmd;
  logic [SB-1:0]    eng_a, eng_b;
  logic [SB-1:0]    eng_matrix = '0;
  logic             eng_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  matrix_op_scheduler #(
    .NUM_REQ(NR), .MATRIX_SIZE_M(MM), .MATRIX_SIZE_N(MN),
    .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req),
    .i_matrix_a_bus(a_bus), .i_matrix_b_bus(b_bus),
    .o_grant(grant), .o_done(done), .o_error(error), .o_matrix(matrix),
    .o_eng_rst_n(eng_rst_n), .o_eng_calc_cmd(calc_cmd),
    .o_eng_matrix_a(eng_a), .o_eng_matrix_b(eng_b),
    .i_eng_matrix(eng_matrix), .i_eng_ready(eng_ready)
  );

  function automatic logic [SB-1:0] msum(input logic [SB-1:0] x, input logic [SB-1:0] y);
    logic [SB-1:0] r;
    r = '0;
    for (int e = 0; e < NE; e++) r[e*DW +: DW] = x[e*DW +: DW] + y[e*DW +: DW];
    return r;
  endfunction

  function automatic logic [SB-1:0] pack6(input int e0, input int e1, input int e2,
                                          input int e3, input int e4, input int e5);
    logic [SB-1:0] r;
    r = {DW'(e5), DW'(e4), DW'(e3), DW'(e2), DW'(e1), DW'(e0)};
    return r;
  endfunction

  task automatic chk(input string name, input logic [SB-1:0] act, input logic [SB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Engine stand-in: clears on its active-low reset, raises ready eng_lat
  // commanded cycles after calc_cmd appears (eng_lat==0: never ready).
  int eng_lat = 2;
  int eng_cnt = 0;
  always @(posedge clk or negedge eng_rst_n) begin
    if (!eng_rst_n) begin
      eng_cnt    <= 0;
      eng_ready  <= 1'b0;
      eng_matrix <= '0;
    end else if (calc_cmd && !eng_ready) begin
      eng_cnt <= eng_cnt + 1;
      if (eng_lat != 0 && eng_cnt + 1 >= eng_lat) begin
        eng_ready  <= 1'b1;
        eng_matrix <= msum(eng_a, eng_b);
      end
    end
  end

  // Reference model: a job timeline counted in clock edges from selection.
  int            m_edge = 0, m_start = 0, m_win = 0, m_rr = NR - 1;
  bit            m_busy = 0, m_fin = 0, m_err = 0;
  logic [SB-1:0] m_sum = '0, m_matrix = '0, m_a = '0, m_b = '0;
  logic [NR-1:0] x_grant = '0, x_done = '0;
  logic          x_error = 1'b0, x_rstn = 1'b0, x_calc = 1'b0;

  function automatic int model_pick(input logic [NR-1:0] r, input int last);
    int idx;
    for (int k = 1; k <= NR; k++) begin
      idx = (last + k) % NR;
      if (((r >> idx) & NR'(1)) != '0) return idx;
    end
    return 0;
  endfunction

  task automatic model_step();
    int i;
    m_edge++;
    x_done = '0;
    if (rst) begin
      m_busy = 0; m_fin = 0; m_rr = NR - 1;
      x_grant = '0; x_error = 1'b0; x_rstn = 1'b0; x_calc = 1'b0;
      m_matrix = '0; m_a = '0; m_b = '0;
      return;
    end
    x_rstn = 1'b1;
    x_calc = 1'b0;
    if (!m_busy) begin
      x_grant = '0;
      x_error = 1'b0;
      if (req != '0) begin
        m_win = model_pick(req, m_rr);
        m_busy = 1;
        m_start = m_edge;
      end
    end else if (m_fin) begin
      x_done = NR'(1) << m_win;
      x_error = m_err;
      if (!m_err) m_matrix = m_sum;
      m_rr = m_win;
      m_busy = 0;
      m_fin = 0;
    end else begin
      i = m_edge - m_start;
      if (i == 1) begin
        x_grant = NR'(1) << m_win;
        m_a = a_bus[m_win*SB +: SB];
        m_b = b_bus[m_win*SB +: SB];
        m_sum = msum(m_a, m_b);
      end else if (i == 2) begin
        x_rstn = 1'b0;
      end else begin
        x_calc = 1'b1;
        if (eng_ready) begin
          m_fin = 1; m_err = 0;
        end else if (i - 2 == TO) begin
          m_fin = 1; m_err = 1;
        end
      end
    end
  endtask

  // Compare process: step the model on each edge, check outputs 1 ns later.
  initial begin : compare_proc
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("m_grant", SB'(grant), SB'(x_grant));
      chk("m_done", SB'(done), SB'(x_done));
      chk("m_error", SB'(error), SB'(x_error));
      chk("m_matrix", matrix, m_matrix);
      chk("m_eng_rst_n", SB'(eng_rst_n), SB'(x_rstn));
      chk("m_calc_cmd", SB'(calc_cmd), SB'(x_calc));
      chk("m_eng_a", eng_a, m_a);
      chk("m_eng_b", eng_b, m_b);
      chk("grant_onehot", SB'($countones(grant) <= 1), SB'(1));
      chk("done_onehot", SB'($countones(done) <= 1), SB'(1));
    end
  end

  task automatic wait_done(output int who);
    who = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done != '0) begin
        for (int j = 0; j < NR; j++) if (done == (NR'(1) << j)) who = j;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL wait_done actual=none_in_100_cycles required=done_pulse");
  endtask

  task automatic wait_grant(input logic [NR-1:0] g);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (grant == g) return;
    end
    checks++; failures++;
    $display("FAIL wait_grant actual=%b required=%b", grant, g);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int who;
    int ncalc;
    int r;

    // Reset state
    rst = 1'b1;
    @(negedge clk);
    chk("rst_grant", SB'(grant), '0);
    chk("rst_eng_rst_n", SB'(eng_rst_n), '0);
    chk("rst_calc", SB'(calc_cmd), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_eng_rst_n", SB'(eng_rst_n), SB'(1));
    $display("txn reset_release eng_rst_n=%0b", eng_rst_n);

    // Single job on requester 0
    a_bus[0*SB +: SB] = pack6(2, 1, 3, 3, 1, 0);
    b_bus[0*SB +: SB] = pack6(2, 1, 3, 3, 1, 0);
    eng_lat = 2;
    req = 4'b0001;
    @(negedge clk);
    chk("t2_grant_edge0", SB'(grant), '0);
    @(negedge clk);
    chk("t2_grant_edge1", SB'(grant), SB'(4'b0001));
    req = '0;
    wait_done(who);
    chk("t2_who", SB'(who), SB'(0));
    chk("t2_error", SB'(error), '0);
    chk("t2_matrix", matrix, pack6(4, 2, 6, 6, 2, 0));
    $display("txn single who=%0d matrix=%h", who, matrix);

    // Reset in the middle of WAIT
    req = 4'b0100;
    eng_lat = 0;
    r = 0;
    for (int c = 0; c < 50 && r == 0; c++) begin
      @(negedge clk);
      if (calc_cmd) r = 1;
    end
    chk("t1_reached_wait", SB'(r), SB'(1));
    rst = 1'b1;
    req = '0;
    #1;
    chk("t1_grant", SB'(grant), '0);
    chk("t1_done", SB'(done), '0);
    chk("t1_error", SB'(error), '0);
    chk("t1_matrix", matrix, '0);
    chk("t1_eng_rst_n", SB'(eng_rst_n), '0);
    chk("t1_calc", SB'(calc_cmd), '0);
    chk("t1_eng_a", eng_a, '0);
    chk("t1_eng_b", eng_b, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_rel_eng_rst_n", SB'(eng_rst_n), SB'(1));
    chk("t1_rel_grant", SB'(grant), '0);
    $display("txn reset_mid_wait eng_rst_n=%0b", eng_rst_n);

    // Round-robin with all requests held
    for (int w = 0; w < NR*SB/32; w++) begin
      a_bus[w*32 +: 32] = $urandom();
      b_bus[w*32 +: 32] = $urandom();
    end
    eng_lat = 1;
    req = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      wait_done(who);
      if (j == 7) req = '0;
      chk("t3_order", SB'(who), SB'(j % NR));
      $display("txn rr job=%0d who=%0d", j, who);
    end

    // Fairness: requester 2 arrives while 1 is being served
    a_bus[1*SB +: SB] = pack6(1, 2, 3, 4, 5, 6);
    b_bus[1*SB +: SB] = pack6(10, 20, 30, 40, 50, 60);
    eng_lat = 3;
    req = 4'b0010;
    wait_grant(4'b0010);
    req = 4'b0110;
    for (int j = 0; j < 3; j++) begin
      wait_done(who);
      if (j == 2) req = '0;
      chk("t4_order", SB'(who), (j == 1) ? SB'(2) : SB'(1));
      $display("txn fair job=%0d who=%0d", j, who);
    end
    chk("t4_matrix", matrix, pack6(11, 22, 33, 44, 55, 66));

    // Timeout: engine never ready
    eng_lat = 0;
    req = 4'b1000;
    ncalc = 0;
    who = -1;
    for (int c = 0; c < 100 && who < 0; c++) begin
      @(negedge clk);
      if (done != '0) begin
        for (int j = 0; j < NR; j++) if (done == (NR'(1) << j)) who = j;
      end else if (calc_cmd) begin
        ncalc++;
      end
    end
    req = '0;
    chk("t5_who", SB'(who), SB'(3));
    chk("t5_error", SB'(error), SB'(1));
    chk("t5_wait_cycles", SB'(ncalc), SB'(TO));
    chk("t5_matrix_held", matrix, pack6(11, 22, 33, 44, 55, 66));
    $display("txn timeout who=%0d error=%0b wait=%0d", who, error, ncalc);
    @(negedge clk);
    chk("t5_error_clear", SB'(error), '0);

    a_bus[3*SB +: SB] = pack6(100, 200, 300, 400, 500, 600);
    b_bus[3*SB +: SB] = pack6(1, 1, 1, 1, 1, 1);
    eng_lat = 3;
    req = 4'b1000;
    wait_done(who);
    req = '0;
    chk("t5_next_who", SB'(who), SB'(3));
    chk("t5_next_error", SB'(error), '0);
    chk("t5_next_matrix", matrix, pack6(101, 201, 301, 401, 501, 601));
    $display("txn after_timeout who=%0d matrix=%h", who, matrix);

    // Operand latch: slot changes and req drops after grant
    a_bus[0*SB +: SB] = pack6(7, 0, 65535, 1, 2, 3);
    b_bus[0*SB +: SB] = pack6(1, 9, 1, 1, 1, 1);
    eng_lat = 4;
    req = 4'b0001;
    wait_grant(4'b0001);
    @(negedge clk);
    a_bus[0*SB +: SB] = pack6(900, 900, 900, 900, 900, 900);
    b_bus[0*SB +: SB] = pack6(5, 5, 5, 5, 5, 5);
    req = '0;
    wait_done(who);
    chk("t6_who", SB'(who), SB'(0));
    chk("t6_matrix", matrix, pack6(8, 9, 0, 2, 3, 4));
    $display("txn latch who=%0d matrix=%h", who, matrix);

    // Randomized traffic, checked cycle by cycle by the model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int w = 0; w < NR*SB/32; w++) begin
        a_bus[w*32 +: 32] = $urandom();
        b_bus[w*32 +: 32] = $urandom();
      end
      if ($urandom_range(0, 3) == 0) req = NR'($urandom_range(0, 15));
      r = int'($urandom_range(0, 9));
      eng_lat = (r == 0) ? 0 : ((r > 7) ? int'($urandom_range(6, 7)) : r);
      if (c == 300) rst = 1'b1;
      if (c == 302) rst = 1'b0;
      if (done != '0) $display("txn random t=%0t done=%b error=%0b", $time, done, error);
    end
    req = '0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
